edge_event_arbiter: RTL
=======================

# edge_event_arbiter

Multi-channel edge-event controller that sits in front of the negative/positive edge detection logic. It watches N single-bit signals and detects a configurable edge type per channel. Each detected edge is latched as a pending event. Pending events are granted round-robin, one at a time, onto a single valid/ready event port that the downstream consumer drains. Dropped events are flagged per channel, so firmware or a checker can see lost edges.

## Interface
- N, 4, number of monitored channels (2..16)
- ID_W, 2, channel-index width; must equal $clog2(N)

- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- signal  input  N  monitored signals; synchronous to clk
- mode  input  2N  per-channel edge select, bits [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both
- evt_ready  input  1  consumer accepts event this cycle
- evt_valid  output  1  event present on evt_id/evt_rise
- evt_id  output  ID_W  channel index of event
- evt_rise  output  1  1 = rising edge, 0 = falling edge
- overflow  output  N  sticky per-channel lost-event flag
- ovf_clr  input  N  per-channel clear for overflow

## Operation
- Previous-value register sig_d[N-1:0] is loaded from signal every cycle.
- primed flag: 0 after reset. The first cycle after reset loads sig_d without detecting edges. No spurious edge is reported for inputs already high at reset.
- Edge detection for channel i at a clock edge (primed=1):
  - rise_i = signal[i] & ~sig_d[i]
  - fall_i = ~signal[i] & sig_d[i]
  - Qualified by mode[i]; both qualified for mode 11.
- Pending state per channel:
  - pend[i] and pdir[i], where pdir[i]=1 means rising.
  - A qualified edge sets pend[i]=1 and pdir[i] to the edge direction.
- Collision, new qualified edge while pend[i]=1:
  - If channel i is not being moved to the output this cycle: the new event is dropped, pend/pdir stay unchanged, and overflow[i] is set.
  - If channel i is being moved to the output this cycle: pend[i] stays 1, pdir[i] takes the new direction, and overflow is not set.
- Output register (evt_valid, evt_id, evt_rise) is a one-entry skid stage.
  - Load condition: evt_valid=0 or (evt_valid & evt_ready).
  - On load: pick the winner among pend bits, searching round-robin from pointer ptr upward with wrap at N-1→0.
  - The winner's id/pdir go to the output, pend[winner] is cleared, and ptr becomes winner+1 mod N.
  - If no pend bit is set, evt_valid goes to 0.
  - While evt_valid=1 and evt_ready=0, evt_id and evt_rise are held stable.
- Mode change to 00 clears pend[i] on the next edge. An event already in the output register is unaffected. Mode changes never generate edges.
- ovf_clr[i] clears overflow[i]. If a set and a clear happen in the same cycle, the set wins.
- Reset at any time clears sig_d, primed, pend, pdir, ptr, the output register and overflow. An in-flight event is discarded.

## Timing
- Reset values:
  - evt_valid=0, evt_id=0, evt_rise=0, overflow=0.
  - ptr=0, primed=0.
- Latency:
  - A change on signal sampled at edge E0 sets pend at E0.
  - evt_valid is asserted after E1 if the output register is free. This is 1 cycle from pend to output.
- Throughput: 1 event per cycle when evt_ready is held high and events are pending.
- Handshake: a transfer occurs on any posedge with evt_valid & evt_ready. evt_valid never drops without a transfer, except on reset.
- Fairness: a continuously pending channel waits at most N-1 grants.

## Test plan
- Reset and prime:
  - Stimulus: hold signal=4'b0101 through reset release, mode all 11, evt_ready=1.
  - Required response: evt_valid stays 0 for 5 cycles and overflow=0.
- Single edges:
  - Stimulus: mode ch0=10; signal[0] 1→0.
  - Required response: evt_valid=1 one cycle after pend, with evt_id=0 and evt_rise=0.
  - Stimulus: ch0 0→1 with mode 10.
  - Required response: no event.
- Round-robin:
  - Stimulus: rising edges on ch1, ch2, ch3 in the same cycle, ptr=0, evt_ready=1.
  - Required response: evt_id sequence 1,2,3 on consecutive cycles.
  - Stimulus: a new simultaneous burst on ch0–ch3.
  - Required response: grant order 0,1,2,3.
- Backpressure:
  - Stimulus: evt_ready=0 for 6 cycles with an event on ch2.
  - Required response: evt_id=2 and evt_rise stay stable and evt_valid stays 1. The transfer occurs on the first cycle with evt_ready=1.
- Overflow:
  - Stimulus: evt_ready=0; ch1 toggles 0→1→0 on 2 edges while pend[1] already set.
  - Required response: overflow[1]=1 and the stored direction is unchanged.
  - Stimulus: ovf_clr[1] pulse while another drop occurs.
  - Required response: overflow[1] stays 1.
  - Stimulus: ovf_clr[1] pulse alone.
  - Required response: overflow[1] clears.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while evt_valid=1 and pend=4'b1010.
  - Required response: all outputs are 0 immediately. After release there are no events until new edges occur post-priming.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Watches N single-bit signals, detects a per-channel configurable edge type,
// latches each detected edge as a pending event and grants pending events
// round-robin, one at a time, onto a single valid/ready event port. Events
// that cannot be latched because the channel already holds a pending event
// set a sticky per-channel overflow flag.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   signal     N monitored signals, synchronous to clk
//   mode       2N per-channel edge select [2i+1:2i]:
//              00 off, 01 rising, 10 falling, 11 both
//   evt_ready  consumer accepts the presented event this cycle
//   evt_valid  event present on evt_id / evt_rise
//   evt_id     channel index of the presented event
//   evt_rise   1 = rising edge, 0 = falling edge
//   overflow   sticky per-channel lost-event flag
//   ovf_clr    per-channel clear for overflow (a same-cycle set wins)
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      signal,
    input  logic [2*N-1:0]    mode,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    output logic              evt_rise,
    output logic [N-1:0]      overflow,
    input  logic [N-1:0]      ovf_clr
);

    logic [N-1:0]    sig_prev_q, sig_prev_d;
    logic            primed_q,   primed_d;
    logic [N-1:0]    pend_q,     pend_d;
    logic [N-1:0]    pdir_q,     pdir_d;
    logic [ID_W-1:0] ptr_q,      ptr_d;
    logic            evt_valid_q, evt_valid_d;
    logic [ID_W-1:0] evt_id_q,    evt_id_d;
    logic            evt_rise_q,  evt_rise_d;
    logic [N-1:0]    overflow_q,  overflow_d;

    logic [N-1:0]    enabled_s;
    logic [N-1:0]    rise_s;
    logic [N-1:0]    fall_s;
    logic [N-1:0]    cand_s;
    logic            found_s;
    logic [ID_W-1:0] win_s;
    logic            load_s;
    logic            grant_s;

    // Per-channel edge detection, qualified by mode and by the primed flag so
    // inputs that are already high when reset releases never look like edges.
    always_comb begin
        enabled_s = '0;
        rise_s    = '0;
        fall_s    = '0;
        for (int i = 0; i < N; i++) begin
            enabled_s[i] = mode[2*i] | mode[2*i+1];
            rise_s[i]    = primed_q & signal[i] & ~sig_prev_q[i] & mode[2*i];
            fall_s[i]    = primed_q & ~signal[i] & sig_prev_q[i] & mode[2*i+1];
        end
    end

    // Round-robin search: first pending, still-enabled channel at or after ptr.
    always_comb begin
        cand_s  = pend_q & enabled_s;
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && cand_s[(int'(ptr_q) + k) % N]) begin
                found_s = 1'b1;
                win_s   = ID_W'((int'(ptr_q) + k) % N);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the output skid stage, pending events and overflow.
    always_comb begin
        load_s      = ~evt_valid_q | evt_ready;
        grant_s     = load_s & found_s;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_rise_d  = evt_rise_q;
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        pdir_d      = pdir_q;
        overflow_d  = overflow_q;
        sig_prev_d  = signal;
        primed_d    = 1'b1;

        if (grant_s) begin
            evt_valid_d = 1'b1;
            evt_id_d    = win_s;
            evt_rise_d  = pdir_q[win_s];
            ptr_d       = (win_s == ID_W'(N - 1)) ? '0 : win_s + ID_W'(1);
        end else if (load_s) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end

        for (int i = 0; i < N; i++) begin
            if (!enabled_s[i]) begin
                pend_d[i] = 1'b0;
            end else if (grant_s && (win_s == ID_W'(i))) begin
                // Channel leaves for the output this cycle, so a fresh edge
                // can take its slot without being counted as lost.
                pend_d[i] = rise_s[i] | fall_s[i];
                pdir_d[i] = (rise_s[i] | fall_s[i]) ? rise_s[i] : pdir_q[i];
            end else if (rise_s[i] | fall_s[i]) begin
                if (pend_q[i]) begin
                    pend_d[i] = pend_q[i];
                end else begin
                    pend_d[i] = 1'b1;
                    pdir_d[i] = rise_s[i];
                end
            end else begin
                pend_d[i] = pend_q[i];
            end

            // Drop detection: set has priority over firmware clear.
            if (enabled_s[i] && pend_q[i] && (rise_s[i] | fall_s[i]) &&
                !(grant_s && (win_s == ID_W'(i)))) begin
                overflow_d[i] = 1'b1;
            end else if (ovf_clr[i]) begin
                overflow_d[i] = 1'b0;
            end else begin
                overflow_d[i] = overflow_q[i];
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_prev_q  <= '0;
            primed_q    <= 1'b0;
            pend_q      <= '0;
            pdir_q      <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_rise_q  <= 1'b0;
            overflow_q  <= '0;
        end else begin
            sig_prev_q  <= sig_prev_d;
            primed_q    <= primed_d;
            pend_q      <= pend_d;
            pdir_q      <= pdir_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_rise_q  <= evt_rise_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_rise  = evt_rise_q;
    assign overflow  = overflow_q;

endmodule
